hash_msg_feeder: RTL
====================

// Module: hash_msg_feeder
// PURPOSE
//  Store-and-forward stage directly upstream of the 32-bit light-hash core. Buffers one whole message arriving
//  as a valid/ready/last byte stream, then replays it to the core as a gap-free burst (M, M_valid, input_length).
//  Captures digest on the core's hash_ready pulse and offers it downstream on a valid/ready port.
//  Core samples M every cycle while busy, so bytes must be contiguous: that is why whole message is buffered first.
// PARAMETERS
//  DEPTH        64   max message bytes held; power of two, >=2
//  ADDR_W       $clog2(DEPTH)   derived, not overridden
//  WDOG_CYCLES  1024 watchdog limit in WAIT (used only with HMF_WDOG_EN)
// PORTS
//  clk           in   1    clock
//  rst_n         in   1    reset, asynchronous, active-low
//  s_data        in   8    message byte from host
//  s_valid       in   1    s_data valid
//  s_last        in   1    final byte of message (qualified by s_valid)
//  s_ready       out  1    feeder accepts byte this cycle
//  m_data        out  8    byte to hash core (M)
//  m_valid       out  1    M_valid to core
//  m_length      out  64   input_length to core, zero-extended byte count
//  hash_ready    in   1    one-cycle done pulse from core
//  digest        in   32   core digest, valid when hash_ready=1
//  o_digest      out  32   captured digest
//  o_valid       out  1    o_digest valid; held until o_ready
//  o_ready       in   1    downstream accepts o_digest
//  ovf           out  1    sticky: current message exceeded DEPTH; cleared at next message's first byte
//  wdog_err      out  1    sticky watchdog flag (tied 0 without HMF_WDOG_EN); cleared by reset only
// BEHAVIOUR
//  Reset: state FILL, wr/rd pointers 0, s_ready=1, m_valid=0, m_data=0, m_length=0, o_valid=0, o_digest=0, ovf=0, wdog_err=0.
//  FSM FILL -> SEND -> WAIT -> FILL.
//  FILL: s_ready=1. Byte accepted on s_valid&&s_ready, written at wr_ptr; len=min(count,DEPTH).
//   Bytes beyond DEPTH dropped, ovf set; message truncated to DEPTH, s_ready stays 1 until s_last.
//   Accepted s_last -> s_ready=0; go SEND on next cycle when o_valid=0, else hold in FILL_DONE until digest taken.
//  SEND: len cycles. Cycle 0: m_valid=1, m_data=buf[0], m_length=len. Cycles 1..len-1: m_valid=1, m_data=buf[i].
//   m_length held constant throughout. Outputs registered; no bubbles permitted.
//   len=1 is a single-cycle burst. After last byte: m_valid=0, m_data=0 -> WAIT.
//  WAIT: hash_ready=1 -> o_digest<=digest, o_valid<=1, pointers cleared, go FILL (s_ready=1 next cycle).
//   hash_ready outside WAIT ignored.
//  Digest port: o_valid falls the cycle after o_valid&&o_ready. Digest arrival can never coincide with pending o_valid (SEND gated).
//  Simultaneous s_valid with entry to FILL: byte accepted only once s_ready=1 is visible (registered ready).
//  Zero-length messages impossible (s_last always carries a byte).
//  rst_n asserted mid-SEND/WAIT: immediate return to reset values; partial message discarded; core is reset by the same rst_n.
// CONFIGURATION
//  HMF_WDOG_EN defined: counter in WAIT; reaching WDOG_CYCLES without hash_ready sets wdog_err,
//   pointers cleared, -> FILL, no o_valid.
//  HMF_WDOG_EN undefined: no counter; WAIT holds indefinitely; wdog_err tied 0.
// STRUCTURE
//  Package hash_feeder_pkg: state enum {FILL, FILL_DONE, SEND, WAIT}, LEN_W=64, BYTE_W=8, DIGEST_W=32.
//  Sub-module hmf_byte_ram: DEPTH x 8 simple dual-port, sync write, registered read (1-cycle).
//   Feeder prefetches buf[0] on FILL_DONE/SEND entry to keep the burst gap-free.
// TESTING
//  1: Send 3 bytes 0x61,0x62,0x63 (last on 0x63) -> SEND burst exactly 3 cycles, m_length=3, m_valid high throughout; one o_valid with o_digest equal to core model.
//  2: Send 1-byte message 0x00 -> single-cycle burst, m_length=1, digest captured, s_ready=1 again after WAIT.
//  3: Send DEPTH+5 bytes -> ovf=1, m_length=DEPTH, only first DEPTH bytes replayed; ovf clears on next message's first byte.
//  4: Hold o_ready=0, send two messages back-to-back -> second waits in FILL_DONE, no m_valid until first digest taken; then two ordered digests.
//  5: Assert rst_n low during SEND of an 8-byte message -> all outputs at reset values same cycle; next 2-byte message hashes correctly.
//  6: With HMF_WDOG_EN and hash_ready forced 0 -> wdog_err=1 after WDOG_CYCLES in WAIT, s_ready=1, o_valid stays 0.

Source files
------------

// File: rtl/hash_feeder_pkg.sv
// Shared types and widths for the hash message feeder.
package hash_feeder_pkg;

  localparam int LEN_W    = 64;
  localparam int BYTE_W   = 8;
  localparam int DIGEST_W = 32;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    FILL_DONE = 2'd1,
    SEND      = 2'd2,
    WAIT      = 2'd3
  } state_e;

endpackage

// File: rtl/hmf_byte_ram.sv
// Message byte buffer: simple dual-port RAM, synchronous write, registered read.
// The read register returns zero when no read is issued, so it can drive M directly.
module hmf_byte_ram
  import hash_feeder_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [BYTE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hash_msg_feeder.sv
// Store-and-forward feeder: buffers one byte-stream message, replays it gap-free to the hash core,
// captures the digest. Optional WAIT watchdog enabled by defining HMF_WDOG_EN.
module hash_msg_feeder
  import hash_feeder_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BYTE_W-1:0]   s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic [BYTE_W-1:0]   m_data,
  output logic                m_valid,
  output logic [LEN_W-1:0]    m_length,
  input  logic                hash_ready,
  input  logic [DIGEST_W-1:0] digest,
  output logic [DIGEST_W-1:0] o_digest,
  output logic                o_valid,
  input  logic                o_ready,
  output logic                ovf,
  output logic                wdog_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WDOG_CYCLES < 1) begin : g_param_check
    $error("hash_msg_feeder: DEPTH must be a power of two >= 2 and WDOG_CYCLES >= 1");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                s_ready_q, s_ready_d;
  logic                m_valid_q, m_valid_d;
  logic [LEN_W-1:0]    m_length_q, m_length_d;
  logic                o_valid_q, o_valid_d;
  logic [DIGEST_W-1:0] o_digest_q, o_digest_d;
  logic                ovf_q, ovf_d;

  logic                ram_we;
  logic                ram_re;
  logic [ADDR_W-1:0]   ram_raddr;

`ifdef HMF_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0]   wdog_cnt_q, wdog_cnt_d;
  logic                wdog_err_q, wdog_err_d;
`endif

  // The RAM read register doubles as the M output register: it is loaded with buf[0]
  // on the cycle that leaves FILL_DONE, so the first burst byte carries no bubble.
  hmf_byte_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (cnt_q[ADDR_W-1:0]),
    .wdata (s_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (m_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    s_ready_d  = s_ready_q;
    m_valid_d  = 1'b0;
    m_length_d = m_length_q;
    o_valid_d  = o_valid_q;
    o_digest_d = o_digest_q;
    ovf_d      = ovf_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_raddr  = rd_ptr_q[ADDR_W-1:0];
`ifdef HMF_WDOG_EN
    wdog_err_d = wdog_err_q;
    wdog_cnt_d = (state_q == WAIT) ? wdog_cnt_q + WDOG_W'(1) : '0;
`endif

    if (o_valid_q && o_ready) begin
      o_valid_d = 1'b0;
    end

    case (state_q)
      FILL: begin
        if (s_valid && s_ready_q) begin
          if (cnt_q == '0) begin
            ovf_d = 1'b0;
          end
          // Bytes past DEPTH are consumed but dropped so the host can still finish the message.
          if (cnt_q < FULL) begin
            ram_we = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (s_last) begin
            s_ready_d = 1'b0;
            state_d   = FILL_DONE;
          end
        end
      end
      FILL_DONE: begin
        if (!o_valid_q) begin
          ram_re     = 1'b1;
          ram_raddr  = '0;
          rd_ptr_d   = CNT_W'(1);
          m_valid_d  = 1'b1;
          m_length_d = LEN_W'(cnt_q);
          state_d    = SEND;
        end
      end
      SEND: begin
        if (rd_ptr_q < cnt_q) begin
          ram_re    = 1'b1;
          m_valid_d = 1'b1;
          rd_ptr_d  = rd_ptr_q + CNT_W'(1);
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (hash_ready) begin
          o_digest_d = digest;
          o_valid_d  = 1'b1;
          cnt_d      = '0;
          rd_ptr_d   = '0;
          s_ready_d  = 1'b1;
          state_d    = FILL;
        end
`ifdef HMF_WDOG_EN
        else if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          wdog_err_d = 1'b1;
          cnt_d      = '0;
          rd_ptr_d   = '0;
          s_ready_d  = 1'b1;
          state_d    = FILL;
        end
`endif
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      s_ready_q  <= 1'b1;
      m_valid_q  <= 1'b0;
      m_length_q <= '0;
      o_valid_q  <= 1'b0;
      o_digest_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
      m_length_q <= m_length_d;
      o_valid_q  <= o_valid_d;
      o_digest_q <= o_digest_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef HMF_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end
  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif

  assign s_ready  = s_ready_q;
  assign m_valid  = m_valid_q;
  assign m_length = m_length_q;
  assign o_valid  = o_valid_q;
  assign o_digest = o_digest_q;
  assign ovf      = ovf_q;

endmodule
